// File: rtl/jpeg_pkg.sv
// Shared definitions for the JPEG AC/DC entropy front end.
// Token field widths, the ZRL token and the AC run-length scheduler states.
package jpeg_pkg;

    localparam int ZRLEN_W    = 4;
    localparam int LEN_W      = 4;
    localparam int AMP_W      = 12;
    localparam int BLK_AC_LEN = 63;

    localparam logic [ZRLEN_W+LEN_W+AMP_W-1:0] ZRL_TOKEN = 20'hF0000;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        ZRL,
        EOB
    } rle_state_e;

endpackage

// File: rtl/ac_amp_size.sv
// Amplitude size classifier: position of the highest set bit of |coef|, plus 1.
// Purely combinational; shared between the AC and DC paths.
module ac_amp_size #(
    parameter int COEF_WIDTH = 12
) (
    input  logic [COEF_WIDTH-1:0] coef_i,
    output logic [3:0]            size_o
);

    logic [COEF_WIDTH-1:0] mag;

    // Magnitude, then a priority scan keeping the highest set bit.
    always_comb begin
        mag    = coef_i[COEF_WIDTH-1]
                 ? (~coef_i + {{(COEF_WIDTH-1){1'b0}}, 1'b1})
                 : coef_i;
        size_o = '0;
        for (int i = 0; i < COEF_WIDTH; i++) begin
            if (mag[i]) begin
                size_o = 4'(i + 1);
            end
        end
    end

endmodule

// File: rtl/ac_rle_sched.sv
// AC zero-run / size sequencer feeding the AC Huffman encoder.
// Emits run/size/amp tokens, ZRL tokens and the EOB request per 8x8 block.
module ac_rle_sched
    import jpeg_pkg::*;
#(
    parameter int AC_IN_WIDTH = 20,
    parameter int COEF_WIDTH  = 12
) (
    input  logic                   clk_x8_i,
    input  logic                   rst_i,
    input  logic                   pic_frame_i,
    input  logic                   coef_valid_i,
    input  logic [COEF_WIDTH-1:0]  coef_i,
    output logic                   coef_ready_o,
    output logic                   ac_data_go_o,
    output logic                   ac_data_valid_o,
    output logic [AC_IN_WIDTH-1:0] ac_data_in_o,
    output logic                   ac_data_last_o,
    output logic                   blk_done_o,
    output logic                   busy_o
);

    rle_state_e             state_q, state_d;
    logic [5:0]             idx_q, idx_d;
    logic [5:0]             zrun_q, zrun_d;
    logic [COEF_WIDTH-1:0]  hold_q, hold_d;
    logic                   go_q, go_d;
    logic                   vld_q, vld_d;
    logic                   last_q, last_d;
    logic                   done_q, done_d;
    logic [AC_IN_WIDTH-1:0] tok_q, tok_d;

    logic [COEF_WIDTH-1:0]  size_src;
    logic [3:0]             size;
    logic [5:0]             cur_idx;
    logic                   accept;
    logic                   is_last;

    assign coef_ready_o = pic_frame_i
                          && (state_q == IDLE || state_q == RUN);
    assign accept       = coef_valid_i && coef_ready_o;
    assign cur_idx      = (state_q == IDLE) ? 6'd1 : idx_q + 6'd1;
    assign is_last      = (cur_idx == 6'(BLK_AC_LEN));
    assign size_src     = (state_q == ZRL) ? hold_q : coef_i;

    ac_amp_size #(
        .COEF_WIDTH(COEF_WIDTH)
    ) u_size (
        .coef_i(size_src),
        .size_o(size)
    );

    // Next-state and next-output decode for the scheduler FSM.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        zrun_d  = zrun_q;
        hold_d  = hold_q;
        go_d    = 1'b0;
        vld_d   = 1'b0;
        last_d  = 1'b0;
        done_d  = 1'b0;
        tok_d   = '0;
        if (!pic_frame_i) begin
            state_d = IDLE;
            idx_d   = '0;
            zrun_d  = '0;
            hold_d  = '0;
        end else begin
            unique case (state_q)
                IDLE, RUN: begin
                    if (accept) begin
                        state_d = RUN;
                        idx_d   = cur_idx;
                        go_d    = (state_q == IDLE);
                        if (coef_i == '0) begin
                            zrun_d = zrun_q + 6'd1;
                            if (is_last) begin
                                state_d = EOB;
                                last_d  = 1'b1;
                                done_d  = 1'b1;
                                zrun_d  = '0;
                            end
                        end else if (zrun_q < 6'd16) begin
                            vld_d  = 1'b1;
                            tok_d  = {zrun_q[3:0], size,
                                      coef_i[AMP_W-1:0]};
                            zrun_d = '0;
                            if (is_last) begin
                                state_d = IDLE;
                                idx_d   = '0;
                                done_d  = 1'b1;
                            end
                        end else begin
                            vld_d   = 1'b1;
                            tok_d   = ZRL_TOKEN;
                            zrun_d  = zrun_q - 6'd16;
                            hold_d  = coef_i;
                            state_d = ZRL;
                        end
                    end
                end
                ZRL: begin
                    vld_d = 1'b1;
                    if (zrun_q >= 6'd16) begin
                        tok_d  = ZRL_TOKEN;
                        zrun_d = zrun_q - 6'd16;
                    end else begin
                        tok_d  = {zrun_q[3:0], size,
                                  hold_q[AMP_W-1:0]};
                        zrun_d = '0;
                        hold_d = '0;
                        if (idx_q == 6'(BLK_AC_LEN)) begin
                            state_d = IDLE;
                            idx_d   = '0;
                            done_d  = 1'b1;
                        end else begin
                            state_d = RUN;
                        end
                    end
                end
                EOB: begin
                    state_d = IDLE;
                    idx_d   = '0;
                    zrun_d  = '0;
                end
            endcase
        end
    end

    // State, counters and registered encoder-side outputs.
    always_ff @(posedge clk_x8_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            idx_q   <= '0;
            zrun_q  <= '0;
            hold_q  <= '0;
            go_q    <= 1'b0;
            vld_q   <= 1'b0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
            tok_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            zrun_q  <= zrun_d;
            hold_q  <= hold_d;
            go_q    <= go_d;
            vld_q   <= vld_d;
            last_q  <= last_d;
            done_q  <= done_d;
            tok_q   <= tok_d;
        end
    end

    assign ac_data_go_o    = go_q;
    assign ac_data_valid_o = vld_q;
    assign ac_data_in_o    = tok_q;
    assign ac_data_last_o  = last_q;
    assign blk_done_o      = done_q;
    assign busy_o          = (state_q != IDLE);

endmodule

// File: tb/tb_ac_rle_sched.sv
// Bench for ac_rle_sched: directed blocks plus random blocks
// checked against a run-length reference model.
module tb_ac_rle_sched;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        pic_frame_i;
    logic        coef_valid_i;
    logic [11:0] coef_i;
    logic        coef_ready_o;
    logic        ac_data_go_o;
    logic        ac_data_valid_o;
    logic [19:0] ac_data_in_o;
    logic        ac_data_last_o;
    logic        blk_done_o;
    logic        busy_o;

    int total = 0;
    int bad   = 0;
    int go_cnt;
    int stalls;

    logic [31:0] obs[$];
    logic [31:0] exq[$];

    localparam logic [31:0] EOB_EV = 32'h0110_0000;
    localparam logic [31:0] ZRL_EV = 32'h000F_0000;

    typedef logic [11:0] blk_t [63];
    blk_t blk;

    ac_rle_sched dut (
        .clk_x8_i       (clk),
        .rst_i          (rst_i),
        .pic_frame_i    (pic_frame_i),
        .coef_valid_i   (coef_valid_i),
        .coef_i         (coef_i),
        .coef_ready_o   (coef_ready_o),
        .ac_data_go_o   (ac_data_go_o),
        .ac_data_valid_o(ac_data_valid_o),
        .ac_data_in_o   (ac_data_in_o),
        .ac_data_last_o (ac_data_last_o),
        .blk_done_o     (blk_done_o),
        .busy_o         (busy_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", tag, got, exp);
        end
    endtask

    // Output event recorder and per-cycle output invariants.
    always @(negedge clk) begin
        if (ac_data_valid_o || ac_data_last_o || blk_done_o)
            obs.push_back({7'b0, ac_data_last_o, 3'b0,
                           blk_done_o, ac_data_in_o});
        if (ac_data_go_o) go_cnt++;
        if (ac_data_valid_o || ac_data_last_o)
            chk("v_l_excl", {31'b0, ac_data_valid_o & ac_data_last_o}, 0);
        if (!ac_data_valid_o)
            chk("idle_data", {12'b0, ac_data_in_o}, 0);
    end

    // Reference: JPEG AC run-length rules applied to a whole block.
    function automatic void model(input blk_t c);
        int z = 0;
        int v, m;
        logic [3:0] sz;
        for (int i = 0; i < 63; i++) begin
            if (c[i] == 12'd0) begin
                z++;
                if (i == 62) exq.push_back(EOB_EV);
            end else begin
                while (z >= 16) begin
                    exq.push_back(ZRL_EV);
                    z -= 16;
                end
                v  = $signed(c[i]);
                m  = (v < 0) ? -v : v;
                sz = 4'($clog2(m + 1));
                exq.push_back({11'b0, (i == 62), z[3:0], sz, c[i]});
                z = 0;
            end
        end
    endfunction

    task automatic put(input logic [11:0] c, input bit first,
                       input bit gaps);
        int n = 0;
        if (gaps) begin
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end
        coef_valid_i = 1'b1;
        coef_i       = c;
        @(negedge clk);
        while (!coef_ready_o && n < 8) begin
            n++;
            stalls++;
            @(negedge clk);
        end
        if (!coef_ready_o) chk("ready_timeout", n, 0);
        @(posedge clk);
        #1;
        coef_valid_i = 1'b0;
        coef_i       = '0;
        if (first) chk("go_after_first", {31'b0, ac_data_go_o}, 1);
    endtask

    task automatic send(input blk_t c, input int n, input bit gaps);
        for (int i = 0; i < n; i++) put(c[i], (i == 0), gaps);
    endtask

    task automatic settle();
        repeat (6) @(posedge clk);
        #1;
    endtask

    task automatic cmp_q(input string tag);
        chk({tag, "_n"}, obs.size(), exq.size());
        for (int i = 0; i < obs.size() && i < exq.size(); i++)
            chk($sformatf("%s_ev%0d", tag, i), obs[i], exq[i]);
        obs.delete();
        exq.delete();
    endtask

    task automatic clr();
        obs.delete();
        exq.delete();
        go_cnt = 0;
        stalls = 0;
        blk    = '{default: '0};
    endtask

    task automatic mid_zrl_block();
        blk     = '{default: '0};
        blk[40] = 12'd7;
        send(blk, 41, 1'b0);
        chk("in_zrl", {30'b0, busy_o, coef_ready_o}, 32'h2);
    endtask

    task automatic after_abort(input string tag);
        chk({tag, "_vld"},  {31'b0, ac_data_valid_o}, 0);
        chk({tag, "_done"}, {31'b0, blk_done_o}, 0);
        chk({tag, "_last"}, {31'b0, ac_data_last_o}, 0);
        chk({tag, "_busy"}, {31'b0, busy_o}, 0);
        clr();
        blk[0] = 12'd5;
        blk[2] = 12'hFFD;
        send(blk, 63, 1'b0);
        settle();
        exq.push_back(32'h0000_3005);
        exq.push_back(32'h0001_2FFD);
        exq.push_back(EOB_EV);
        cmp_q({tag, "_next"});
        chk({tag, "_go"}, go_cnt, 1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_i        = 1'b1;
        pic_frame_i  = 1'b1;
        coef_valid_i = 1'b0;
        coef_i       = '0;
        go_cnt       = 0;
        stalls       = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_go",   {31'b0, ac_data_go_o}, 0);
        chk("rst_vld",  {31'b0, ac_data_valid_o}, 0);
        chk("rst_data", {12'b0, ac_data_in_o}, 0);
        chk("rst_last", {31'b0, ac_data_last_o}, 0);
        chk("rst_done", {31'b0, blk_done_o}, 0);
        chk("rst_busy", {31'b0, busy_o}, 0);
        chk("rst_rdy",  {31'b0, coef_ready_o}, 1);
        rst_i = 1'b0;
        @(posedge clk);
        #1;

        clr();
        send(blk, 63, 1'b0);
        chk("z_eob_rdy", {31'b0, coef_ready_o}, 0);
        chk("z_eob_ld", {30'b0, ac_data_last_o, blk_done_o}, 32'h3);
        @(posedge clk);
        #1;
        chk("z_rdy_back", {31'b0, coef_ready_o}, 1);
        settle();
        exq.push_back(EOB_EV);
        cmp_q("zeros");
        chk("z_go_cnt", go_cnt, 1);
        chk("z_stalls", stalls, 0);

        clr();
        blk[0] = 12'd5;
        blk[2] = 12'hFFD;
        send(blk, 63, 1'b0);
        settle();
        exq.push_back(32'h0000_3005);
        exq.push_back(32'h0001_2FFD);
        exq.push_back(EOB_EV);
        cmp_q("two_tok");

        clr();
        blk[40] = 12'd7;
        send(blk, 63, 1'b0);
        settle();
        exq.push_back(ZRL_EV);
        exq.push_back(ZRL_EV);
        exq.push_back(32'h0008_3007);
        exq.push_back(EOB_EV);
        cmp_q("zrl2");
        chk("zrl2_stalls", stalls, 2);

        clr();
        blk[62] = 12'hFFF;
        send(blk, 63, 1'b0);
        settle();
        exq.push_back(ZRL_EV);
        exq.push_back(ZRL_EV);
        exq.push_back(ZRL_EV);
        exq.push_back(32'h001E_1FFF);
        cmp_q("zrl3_last");

        clr();
        blk[0] = 12'h7FF;
        blk[1] = 12'hC00;
        blk[2] = 12'h001;
        send(blk, 63, 1'b0);
        settle();
        exq.push_back(32'h0000_B7FF);
        exq.push_back(32'h0000_BC00);
        exq.push_back(32'h0000_1001);
        exq.push_back(EOB_EV);
        cmp_q("sizes");

        clr();
        mid_zrl_block();
        pic_frame_i = 1'b0;
        @(posedge clk);
        #1;
        pic_frame_i = 1'b1;
        after_abort("abort");

        clr();
        mid_zrl_block();
        rst_i = 1'b1;
        @(posedge clk);
        #1;
        rst_i = 1'b0;
        after_abort("reset");

        for (int r = 0; r < 3; r++) begin
            clr();
            for (int b = 0; b < 2; b++) begin
                for (int i = 0; i < 63; i++) begin
                    int m;
                    if ($urandom_range(0, 99) < 80) begin
                        blk[i] = '0;
                    end else begin
                        m = $urandom_range(1, 2047);
                        blk[i] = $urandom_range(0, 1)
                                 ? 12'(-m) : 12'(m);
                    end
                end
                model(blk);
                send(blk, 63, 1'b1);
            end
            settle();
            cmp_q($sformatf("rnd%0d", r));
            chk($sformatf("rnd%0d_go", r), go_cnt, 2);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
